// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
package div_pkg;

   localparam int DIV_W = 32;
   localparam int DIV_STEPS = 32;
   localparam logic [DIV_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/div_seq_if.sv
// Start/done handshake and operand/result bus between the control unit and the divider.
interface div_seq_if #(
   parameter int WIDTH = 32
);
   logic               start;
   logic [WIDTH-1:0]   regA;
   logic [WIDTH-1:0]   regB;
   logic [2*WIDTH-1:0] regZ;
   logic               busy;
   logic               done;
   logic               div_by_zero;

   modport master (
      output start, regA, regB,
      input  regZ, busy, done, div_by_zero
   );

   modport slave (
      input  start, regA, regB,
      output regZ, busy, done, div_by_zero
   );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes; purely combinational.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   rem_o,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;

   // The top bit of trial is the borrow: set means the divisor did not fit.
   always_comb begin
      shifted = {rem_i, q_i[WIDTH-1]};
      trial   = shifted - {2'b00, divisor_i};
      if (!trial[WIDTH+1]) begin
         rem_o = trial[WIDTH:0];
         q_o   = {q_i[WIDTH-2:0], 1'b1};
      end else begin
         rem_o = shifted[WIDTH:0];
         q_o   = {q_i[WIDTH-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed restoring divider: IDLE -> RUN (32 steps) -> FIX (signs) -> DONE.
module div_seq
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_W
) (
   input  logic     clk,
   input  logic     clr,
   div_seq_if.slave bus
);
   localparam int CNT_W = $clog2(DIV_STEPS);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH:0]     rem_q, rem_d, rem_step;
   logic [WIDTH-1:0]   quo_q, quo_d, quo_step;
   logic [WIDTH-1:0]   divisor_q, divisor_d;
   logic               sign_r_q, sign_r_d;
   logic               sign_q_q, sign_q_d;
   logic [2*WIDTH-1:0] z_q, z_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   rem_fix, quo_fix;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .q_i       (quo_q),
      .divisor_i (divisor_q),
      .rem_o     (rem_step),
      .q_o       (quo_step)
   );

   assign rem_fix = sign_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
   assign quo_fix = sign_q_q ? -quo_q : quo_q;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      divisor_d = divisor_q;
      sign_r_d  = sign_r_q;
      sign_q_d  = sign_q_q;
      z_d       = z_q;
      dz_d      = dz_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               // Negating 0x8000_0000 yields 0x8000_0000, which is read back as unsigned 2^31.
               quo_d     = bus.regA[WIDTH-1] ? -bus.regA : bus.regA;
               divisor_d = bus.regB[WIDTH-1] ? -bus.regB : bus.regB;
               rem_d     = '0;
               sign_r_d  = bus.regA[WIDTH-1];
               sign_q_d  = bus.regA[WIDTH-1] ^ bus.regB[WIDTH-1];
               cnt_d     = '0;
               if (bus.regB == '0) begin
                  z_d     = {bus.regA, WIDTH'(DIV0_QUOT)};
                  dz_d    = 1'b1;
                  state_d = S_DONE;
               end else begin
                  z_d     = '0;
                  dz_d    = 1'b0;
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DIV_STEPS - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            z_d     = {rem_fix, quo_fix};
            state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
         sign_r_q  <= 1'b0;
         sign_q_q  <= 1'b0;
         z_q       <= '0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         divisor_q <= divisor_d;
         sign_r_q  <= sign_r_d;
         sign_q_q  <= sign_q_d;
         z_q       <= z_d;
         dz_q      <= dz_d;
      end
   end

   assign bus.regZ        = z_q;
   assign bus.div_by_zero = dz_q;
   assign bus.busy        = (state_q == S_RUN) || (state_q == S_FIX);
   assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_div_seq.sv
// Directed and small random self-checking bench for the sequential signed divider.
module tb_div_seq;
   logic clk = 1'b0;
   logic clr;

   div_seq_if #(.WIDTH(32)) bus ();

   div_seq #(.WIDTH(32)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Launch one divide from an IDLE cycle (#1 after an edge) and follow it to done.
   // Returns one cycle after done so the next call starts back-to-back.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] z, output logic dz,
                          output logic [63:0] z_first, output int lat, output int busy_cnt);
      bus.regA  = a;
      bus.regB  = b;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.regA  = ~a;
      bus.regB  = 32'd5;
      z_first   = bus.regZ;
      lat       = 0;
      busy_cnt  = 0;
      for (int c = 1; c <= 40; c++) begin
         if (bus.done) begin
            lat = c;
            break;
         end
         if (bus.busy) busy_cnt++;
         @(posedge clk); #1;
      end
      z  = bus.regZ;
      dz = bus.div_by_zero;
      if (lat == 0) check("timeout_done", 64'(bus.done), 64'd1);
      @(posedge clk); #1;
      check("done_pulse", 64'(bus.done), 64'd0);
      check("z_hold", bus.regZ, z);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] z;
   } vec_t;

   vec_t vecs[6];
   logic [63:0] z, z_first;
   logic        dz;
   int          lat, busy_cnt;

   initial begin
      vecs[0] = '{32'd100,       32'd7,         {32'd2,         32'd14}};
      vecs[1] = '{-32'sd100,     32'd7,         {32'hFFFF_FFFE, 32'hFFFF_FFF2}};
      vecs[2] = '{32'd100,       -32'sd7,       {32'd2,         32'hFFFF_FFF2}};
      vecs[3] = '{-32'sd100,     -32'sd7,       {32'hFFFF_FFFE, 32'd14}};
      vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, {32'd0,         32'h8000_0000}};
      vecs[5] = '{32'hFFFF_FFFF, 32'd1,         {32'd0,         32'hFFFF_FFFF}};

      bus.start = 1'b0;
      bus.regA  = '0;
      bus.regB  = '0;
      clr       = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_regZ", bus.regZ, 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_dz", 64'(bus.div_by_zero), 64'd0);
      clr = 1'b0;
      @(posedge clk); #1;

      // Test 1: latency and busy window.
      run_div(vecs[0].a, vecs[0].b, z, dz, z_first, lat, busy_cnt);
      check("t1_z", z, vecs[0].z);
      check("t1_latency", 64'(lat), 64'd34);
      check("t1_busy_cycles", 64'(busy_cnt), 64'd33);
      check("t1_dz", 64'(dz), 64'd0);

      // Tests 2-3: sign combinations and overflow corners, back-to-back.
      for (int i = 1; i < 6; i++) begin
         run_div(vecs[i].a, vecs[i].b, z, dz, z_first, lat, busy_cnt);
         check($sformatf("vec%0d_z", i), z, vecs[i].z);
         check($sformatf("vec%0d_clear", i), z_first, 64'd0);
         check($sformatf("vec%0d_dz", i), 64'(dz), 64'd0);
      end

      // Test 4: divide by zero, then a normal divide clears the flag.
      run_div(32'd55, 32'd0, z, dz, z_first, lat, busy_cnt);
      check("t4_z", z, {32'd55, 32'hFFFF_FFFF});
      check("t4_dz", 64'(dz), 64'd1);
      check("t4_latency", 64'(lat), 64'd1);
      check("t4_busy_cycles", 64'(busy_cnt), 64'd0);
      run_div(32'd10, 32'd3, z, dz, z_first, lat, busy_cnt);
      check("t4b_z", z, {32'd1, 32'd3});
      check("t4b_dz", 64'(dz), 64'd0);
      check("t4b_clear", z_first, 64'd0);

      // Test 5: start while busy is ignored; clr aborts mid-divide.
      bus.regA  = 32'd100;
      bus.regB  = 32'd7;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      bus.regA  = 32'd9;
      bus.regB  = 32'd3;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("t5_still_busy", 64'(bus.busy), 64'd1);
      check("t5_no_restart_z", bus.regZ, 64'd0);
      repeat (9) begin
         @(posedge clk); #1;
      end
      check("t5_busy_before_clr", 64'(bus.busy), 64'd1);
      clr = 1'b1;
      #1;
      check("t5_clr_regZ", bus.regZ, 64'd0);
      check("t5_clr_busy", 64'(bus.busy), 64'd0);
      check("t5_clr_done", 64'(bus.done), 64'd0);
      check("t5_clr_dz", 64'(bus.div_by_zero), 64'd0);
      #2 clr = 1'b0;
      @(posedge clk); #1;
      check("t5_idle_after_clr", 64'(bus.busy), 64'd0);
      run_div(32'd9, 32'd3, z, dz, z_first, lat, busy_cnt);
      check("t5_fresh_z", z, {32'd0, 32'd3});
      check("t5_fresh_latency", 64'(lat), 64'd34);

      // Test 6: random signed pairs, back-to-back, against the language operators.
      for (int i = 0; i < 100; i++) begin
         int signed sa, sb, eq, er;
         sa = int'($urandom);
         sb = (i % 2 == 0) ? int'($urandom) : int'($urandom_range(200)) - 100;
         if (sb == 0) sb = 3;
         if (sa == 32'sh8000_0000 && sb == -1) sb = 2;
         eq = sa / sb;
         er = sa % sb;
         run_div(sa, sb, z, dz, z_first, lat, busy_cnt);
         check($sformatf("rnd%0d %0d/%0d", i, sa, sb), z, {er, eq});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
